// File: rtl/wb_pkg.sv
// Shared encodings for the register-file write-back stage: source selects and FSM states.
package wb_pkg;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_IMM  = 2'd2;
   localparam logic [1:0] WB_LINK = 2'd3;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational 4:1 write-value selector (ALU / MEM / IMM / LINK), DATA_W bits wide, no extension.
module wb_src_mux
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [1:0]        sel_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic [DATA_W-1:0] mem_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [DATA_W-1:0] link_i,
   output logic [DATA_W-1:0] data_o
);

   always_comb begin
      data_o = alu_i;
      case (sel_i)
         WB_ALU:  data_o = alu_i;
         WB_MEM:  data_o = mem_i;
         WB_IMM:  data_o = imm_i;
         WB_LINK: data_o = link_i;
         default: data_o = alu_i;
      endcase
   end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back stage with a stall handshake for variable-latency memory reads.
// Optional memory-wait timeout (mem_err_o pulse, aborted write) enabled by WB_MEM_TIMEOUT_EN.
//
//   state      | meaning
//   S_IDLE     | ready; ALU/IMM/LINK written next edge, MEM moves to wait
//   S_WAIT_MEM | upstream stalled until mem_rvalid_i (or timeout) completes the MEM op
module wb_select_stage
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RADDR_W  = 3,
   parameter bit          ZERO_REG = 1'b1,
   parameter int          TIMEOUT  = 15
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [1:0]         wb_sel_i,
   input  logic               reg_write_i,
   input  logic [RADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0]  alu_result_i,
   input  logic [DATA_W-1:0]  imm_val_i,
   input  logic [DATA_W-1:0]  link_val_i,
   input  logic [DATA_W-1:0]  mem_rdata_i,
   input  logic               mem_rvalid_i,
   output logic               rf_we_o,
   output logic [RADDR_W-1:0] rf_waddr_o,
   output logic [DATA_W-1:0]  rf_wdata_o,
   output logic               mem_err_o
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("wb_select_stage: TIMEOUT must be at least 1");
   end

   wb_state_e          state_q, state_d;
   logic               rf_we_q, rf_we_d;
   logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
   logic               pend_we_q, pend_we_d;
   logic [RADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic               mem_err_q, mem_err_d;
   logic [DATA_W-1:0]  src_data;
   logic               eff_we;

`ifdef WB_MEM_TIMEOUT_EN
   localparam int unsigned        CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0]              cnt_q, cnt_d;
`endif

   wb_src_mux #(
      .DATA_W (DATA_W)
   ) u_src_mux (
      .sel_i  (wb_sel_i),
      .alu_i  (alu_result_i),
      .mem_i  (mem_rdata_i),
      .imm_i  (imm_val_i),
      .link_i (link_val_i),
      .data_o (src_data)
   );

   assign eff_we     = reg_write_i & ~(ZERO_REG & (rd_addr_i == '0));
   assign in_ready_o = (state_q == S_IDLE);

   always_comb begin
      state_d     = state_q;
      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      pend_we_d   = pend_we_q;
      pend_addr_d = pend_addr_q;
      mem_err_d   = 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               if (wb_sel_i == WB_MEM) begin
                  state_d     = S_WAIT_MEM;
                  pend_we_d   = eff_we;
                  pend_addr_d = rd_addr_i;
`ifdef WB_MEM_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end else begin
                  rf_we_d = eff_we;
                  // address/data only move on a real write so they hold otherwise
                  if (eff_we) begin
                     rf_waddr_d = rd_addr_i;
                     rf_wdata_d = src_data;
                  end
               end
            end
         end
         S_WAIT_MEM: begin
            if (mem_rvalid_i) begin
               state_d = S_IDLE;
               rf_we_d = pend_we_q;
               if (pend_we_q) begin
                  rf_waddr_d = pend_addr_q;
                  rf_wdata_d = mem_rdata_i;
               end
            end
`ifdef WB_MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d   = S_IDLE;
               mem_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         pend_we_q   <= 1'b0;
         pend_addr_q <= '0;
         mem_err_q   <= 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         pend_we_q   <= pend_we_d;
         pend_addr_q <= pend_addr_d;
         mem_err_q   <= mem_err_d;
`ifdef WB_MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign mem_err_o  = mem_err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed scenarios plus randomized traffic against a
// transaction-level model. Timeout scenarios run when WB_MEM_TIMEOUT_EN is defined.
module tb_wb_select_stage;

   localparam int DATA_W   = 8;
   localparam int RADDR_W  = 3;
   localparam bit ZERO_REG = 1'b1;
   localparam int TIMEOUT  = 4;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         wb_sel;
   logic               reg_write;
   logic [RADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0]  alu_result;
   logic [DATA_W-1:0]  imm_val;
   logic [DATA_W-1:0]  link_val;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_rvalid;
   logic               rf_we;
   logic [RADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]  rf_wdata;
   logic               mem_err;

   int n_checks = 0;
   int n_errors = 0;

   // model: a pending memory op plus the last issued write
   bit                 m_busy;
   bit                 m_pwe;
   logic [RADDR_W-1:0] m_paddr;
   int                 m_waited;
   logic               m_we;
   logic [RADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0]  m_wdata;
   logic               m_err;

   wb_select_stage #(
      .DATA_W   (DATA_W),
      .RADDR_W  (RADDR_W),
      .ZERO_REG (ZERO_REG),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .wb_sel_i     (wb_sel),
      .reg_write_i  (reg_write),
      .rd_addr_i    (rd_addr),
      .alu_result_i (alu_result),
      .imm_val_i    (imm_val),
      .link_val_i   (link_val),
      .mem_rdata_i  (mem_rdata),
      .mem_rvalid_i (mem_rvalid),
      .rf_we_o      (rf_we),
      .rf_waddr_o   (rf_waddr),
      .rf_wdata_o   (rf_wdata),
      .mem_err_o    (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_pwe    = 1'b0;
      m_paddr  = '0;
      m_waited = 0;
      m_we     = 1'b0;
      m_waddr  = '0;
      m_wdata  = '0;
      m_err    = 1'b0;
   endtask

   task automatic model_write(input bit we, input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      m_we = we;
      if (we) begin
         m_waddr = a;
         m_wdata = d;
      end
   endtask

   // advance the model across one rising edge using the inputs presented before it
   task automatic model_step();
      bit w;
      logic [DATA_W-1:0] v;
      if (!rst_n) return;
      m_we  = 1'b0;
      m_err = 1'b0;
      if (!m_busy) begin
         if (in_valid) begin
            w = reg_write && !(ZERO_REG && rd_addr == 0);
            if (wb_sel == 2'd1) begin
               m_busy   = 1'b1;
               m_pwe    = w;
               m_paddr  = rd_addr;
               m_waited = 0;
            end else begin
               v = (wb_sel == 2'd0) ? alu_result : (wb_sel == 2'd2) ? imm_val : link_val;
               model_write(w, rd_addr, v);
            end
         end
      end else begin
         m_waited++;
         if (mem_rvalid) begin
            model_write(m_pwe, m_paddr, mem_rdata);
            m_busy = 1'b0;
         end
`ifdef WB_MEM_TIMEOUT_EN
         else if (m_waited == TIMEOUT) begin
            m_busy = 1'b0;
            m_err  = 1'b1;
         end
`endif
      end
   endtask

   always @(negedge clk) begin
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("mem_err", 32'(mem_err), 32'(m_err));
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] sel, input bit rw, input logic [RADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] d, input bit rv, input logic [DATA_W-1:0] md);
      in_valid   = v;
      wb_sel     = sel;
      reg_write  = rw;
      rd_addr    = rd;
      alu_result = d;
      imm_val    = d;
      link_val   = d;
      mem_rvalid = rv;
      mem_rdata  = md;
   endtask

   task automatic drive_random(input int rv_pct);
      in_valid   = ($urandom_range(0, 99) < 70);
      wb_sel     = 2'($urandom_range(0, 3));
      reg_write  = ($urandom_range(0, 99) < 80);
      rd_addr    = RADDR_W'($urandom);
      alu_result = DATA_W'($urandom);
      imm_val    = DATA_W'($urandom);
      link_val   = DATA_W'($urandom);
      mem_rdata  = DATA_W'($urandom);
      mem_rvalid = ($urandom_range(0, 99) < rv_pct);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int low_cnt;
      rst_n = 1'b1;
      model_reset();
      drive_random(50);
      #1 rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         drive_random(50);
         tick();
      end
      chk("reset rf_we", 32'(rf_we), 32'h0);
      chk("reset rf_wdata", 32'(rf_wdata), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);
      rst_n = 1'b1;

      // ALU write, 1-cycle latency
      drive(1, 2'd0, 1, 3'd3, 8'h5A, 0, 8'h00);
      tick();
      chk("alu rf_we", 32'(rf_we), 32'h1);
      chk("alu rf_waddr", 32'(rf_waddr), 32'h3);
      chk("alu rf_wdata", 32'(rf_wdata), 32'h5A);
      chk("model alu wdata", 32'(m_wdata), 32'h5A);

      // back-to-back IMM then LINK
      drive(1, 2'd2, 1, 3'd1, 8'h11, 0, 8'h00);
      tick();
      chk("imm rf_we", 32'(rf_we), 32'h1);
      chk("imm rf_wdata", 32'(rf_wdata), 32'h11);
      drive(1, 2'd3, 1, 3'd2, 8'h22, 0, 8'h00);
      tick();
      chk("link rf_we", 32'(rf_we), 32'h1);
      chk("link rf_waddr", 32'(rf_waddr), 32'h2);
      chk("link rf_wdata", 32'(rf_wdata), 32'h22);
      drive(0, 2'd0, 0, 3'd0, 8'h00, 0, 8'h00);
      tick();
      chk("idle rf_we", 32'(rf_we), 32'h0);
      chk("idle hold wdata", 32'(rf_wdata), 32'h22);

      // MEM with rvalid on the 4th wait cycle; upstream traffic while stalled must be ignored
      drive(1, 2'd1, 1, 3'd4, 8'h00, 0, 8'h00);
      tick();
      low_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'd0, 1, 3'd5, 8'hFF, (i == 3), 8'hC3);
         if (!in_ready) low_cnt++;
         tick();
      end
      chk("mem stall cycles", 32'(low_cnt), 32'd4);
      chk("mem rf_we", 32'(rf_we), 32'h1);
      chk("mem rf_waddr", 32'(rf_waddr), 32'h4);
      chk("mem rf_wdata", 32'(rf_wdata), 32'hC3);
      chk("mem in_ready", 32'(in_ready), 32'h1);
      drive(0, 2'd0, 0, 3'd0, 8'h00, 0, 8'h00);
      tick();
      chk("mem pulse width", 32'(rf_we), 32'h0);

      // ALU to r0 suppressed, then stray rvalid in IDLE
      drive(1, 2'd0, 1, 3'd0, 8'h77, 0, 8'h00);
      tick();
      chk("r0 rf_we", 32'(rf_we), 32'h0);
      chk("r0 hold wdata", 32'(rf_wdata), 32'hC3);
      drive(0, 2'd0, 0, 3'd0, 8'h00, 1, 8'hEE);
      tick();
      chk("stray rf_we", 32'(rf_we), 32'h0);
      chk("stray in_ready", 32'(in_ready), 32'h1);

      // reset in the middle of a memory wait drops the pending write
      drive(1, 2'd1, 1, 3'd6, 8'h00, 0, 8'h00);
      tick();
      drive(0, 2'd0, 0, 3'd0, 8'h00, 0, 8'h00);
      tick();
      chk("wait in_ready", 32'(in_ready), 32'h0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst mid-wait in_ready", 32'(in_ready), 32'h1);
      #1 rst_n = 1'b1;
      drive(0, 2'd0, 0, 3'd0, 8'h00, 1, 8'hAB);
      tick();
      chk("rst mid-wait rf_we", 32'(rf_we), 32'h0);
      chk("rst mid-wait wdata", 32'(rf_wdata), 32'h0);

`ifdef WB_MEM_TIMEOUT_EN
      drive(1, 2'd1, 1, 3'd2, 8'h00, 0, 8'h00);
      tick();
      drive(0, 2'd0, 0, 3'd0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to no early err", 32'(mem_err), 32'h0);
      end
      tick();
      chk("to mem_err", 32'(mem_err), 32'h1);
      chk("to rf_we", 32'(rf_we), 32'h0);
      chk("to in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("to err pulse", 32'(mem_err), 32'h0);
      drive(1, 2'd1, 1, 3'd2, 8'h00, 0, 8'h00);
      tick();
      drive(0, 2'd0, 0, 3'd0, 8'h00, 0, 8'h00);
      tick();
      tick();
      tick();
      drive(0, 2'd0, 0, 3'd0, 8'h00, 1, 8'h5C);
      tick();
      chk("to race rf_we", 32'(rf_we), 32'h1);
      chk("to race wdata", 32'(rf_wdata), 32'h5C);
      chk("to race mem_err", 32'(mem_err), 32'h0);
`endif

      // randomized traffic with varying memory latency and occasional async reset
      for (int i = 0; i < 3000; i++) begin
         drive_random((i < 1500) ? 35 : 12);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            chk("rnd rst in_ready", 32'(in_ready), 32'h1);
            rst_n = 1'b1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
